// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier: W x W operands, 2W-bit product with Z/N/C/V flags.
// One conditional add-and-shift per clock; signed operands are handled as magnitudes plus a sign fix-up.
module mul_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] prod_hi,
    output logic [W-1:0] prod_lo,
    output logic         Z,
    output logic         N,
    output logic         C,
    output logic         V
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  step;
    logic           neg;

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     sum;
    logic [2*W-1:0] result;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        // The most negative operand negates to itself, which is exactly its unsigned magnitude.
        mag_a  = (signed_op && A[W-1]) ? -A : A;
        mag_b  = (signed_op && B[W-1]) ? -B : B;
        sum    = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
        result = neg ? -acc : acc;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            step    <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= signed_op & (A[W-1] ^ B[W-1]);
                        acc    <= '0;
                        step   <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    // The add's carry-out becomes the new MSB as the accumulator shifts right.
                    acc    <= {sum, acc[W-1:1]};
                    mplier <= mplier >> 1;
                    step   <= step + CW'(1);
                    if (step == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    prod_hi <= result[2*W-1:W];
                    prod_lo <= result[W-1:0];
                    Z       <= (result == '0);
                    N       <= result[2*W-1];
                    C       <= (result[2*W-1:W] != '0);
                    V       <= (result[2*W-1:W] != {W{result[W-1]}});
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
